// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants, FSM encoding and segment arithmetic for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int IFU_ADDR_W    = 20;
  localparam int IFU_DATA_W    = 8;
  localparam int IFU_QDEPTH    = 4;
  localparam int IFU_SEG_SHIFT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [IFU_ADDR_W-1:0] seg_base(input logic [15:0] cs);
    return {cs, {IFU_SEG_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// Prefetch byte FIFO: wrap-around pointers, occupancy count, synchronous clear.
module instr_fetch_unit_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = IFU_QDEPTH,
  parameter int WIDTH = IFU_DATA_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && valid_o;
  // At full a push is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: forms CS:IP physical address, runs a req/ack byte read and
// feeds fetched bytes to the prefetch queue, pulsing ip_inc per accepted byte.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W,
  parameter int DATA_W = IFU_DATA_W,
  parameter int QDEPTH = IFU_QDEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       cs_in,
  input  logic [ADDR_W-1:0] ip_in,
  output logic              ip_inc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  input  logic              q_pop,
  output logic              busy
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ip_inc_q, mem_req_q;
  logic              q_full, q_push, can_start;

  // A pending ip_inc has not reached ip_in yet, so fold it into the next address.
  assign addr_d    = ADDR_W'(seg_base(cs_in)) + ip_in + ADDR_W'(ip_inc_q);
  assign q_push    = (state_q == ST_REQ) && mem_ack && !flush;
  assign can_start = !flush && (!q_full || (q_pop && q_valid));

  assign ip_inc   = ip_inc_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = addr_q;
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      ip_inc_q  <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      ip_inc_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (can_start) begin
            state_q   <= ST_REQ;
            addr_q    <= addr_d;
            mem_req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            ip_inc_q  <= !flush;
          end else if (flush) begin
            state_q <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  instr_fetch_unit_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (DATA_W)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (flush),
    .push_i  (q_push),
    .data_i  (mem_rdata),
    .pop_i   (q_pop),
    .valid_o (q_valid),
    .data_o  (q_data),
    .full_o  (q_full)
  );

endmodule
